hwpe_dma_loader: RTL and testbench

- Autonomous preload sequencer for the HWPE DMA write port (dma_wen/dma_wa/dma_wd).
- Reads 64-bit words from a source memory and loads feature-map bank 1, feature-map bank 2 and kernel SRAM, in that order.
- Raises completion flags before the MCU issues EAI conv instructions.
- Sits between the system memory fabric and the hwpe top.

---
 rtl/hwpe_dma_loader.sv | 108 ++++++++++
 tb/tb_hwpe_dma_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_dma_loader.sv
// hwpe_dma_loader: streams 64-bit source words into the HWPE DMA write port,
// loading fmap bank 1, fmap bank 2 and kernel SRAM in that order.
module hwpe_dma_loader #(
    parameter int HWPE_ADDR_WIDTH = 16,
    parameter int SRC_ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTD      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SRC_ADDR_WIDTH-1:0]  cfg_fmap_src1,
    input  logic [SRC_ADDR_WIDTH-1:0]  cfg_fmap_src2,
    input  logic [HWPE_ADDR_WIDTH-1:0] cfg_fmap_dst2,
    input  logic [CNT_WIDTH-1:0]       cfg_fmap_words,
    input  logic [SRC_ADDR_WIDTH-1:0]  cfg_kern_src,
    input  logic [HWPE_ADDR_WIDTH-1:0] cfg_kern_dst,
    input  logic [CNT_WIDTH-1:0]       cfg_kern_words,
    output logic                       src_req_valid,
    input  logic                       src_req_ready,
    output logic [SRC_ADDR_WIDTH-1:0]  src_req_addr,
    input  logic                       src_rsp_valid,
    input  logic [63:0]                src_rsp_data,
    output logic                       dma_wen,
    output logic [HWPE_ADDR_WIDTH-1:0] dma_wa,
    output logic [63:0]                dma_wd,
    output logic                       busy,
    output logic                       done,
    output logic                       fmap_done,
    output logic                       kernel_done
);
    localparam logic [SRC_ADDR_WIDTH-1:0]  SRC_MASK = ~SRC_ADDR_WIDTH'(7);
    localparam logic [HWPE_ADDR_WIDTH-1:0] DST_MASK = ~HWPE_ADDR_WIDTH'(7);
    typedef enum logic [2:0] {IDLE, FMAP1, FMAP2, KERN, DONE} state_t;
    state_t                     state, nxt;
    logic [SRC_ADDR_WIDTH-1:0]  src1, src2, ksrc, src_base;
    logic [HWPE_ADDR_WIDTH-1:0] dst2, kdst, dst_base;
    logic [CNT_WIDTH-1:0]       fwords, kwords, words, issued, written;
    logic [2:0]                 outstd;
    logic                       req_hs, rsp_ok, phase_end;
    always_comb begin
        src_base = state == FMAP1 ? src1 : state == FMAP2 ? src2 : state == KERN ? ksrc : '0;
        dst_base = state == FMAP2 ? dst2 : state == KERN ? kdst : '0;
        words = (state == FMAP1 || state == FMAP2) ? fwords : state == KERN ? kwords : '0;
        src_req_valid = issued < words && outstd < 3'(MAX_OUTSTD);
        src_req_addr = src_base + (SRC_ADDR_WIDTH'(issued) << 3);
        req_hs = src_req_valid && src_req_ready;
        rsp_ok = src_rsp_valid && outstd != 3'd0;
        // a phase closes in the cycle its last write is on the port
        phase_end = words != '0 && written == words;
        nxt = state == IDLE ? (!start ? IDLE : cfg_fmap_words != '0 ? FMAP1 :
                               cfg_kern_words != '0 ? KERN : DONE) :
              state == DONE ? IDLE :
              !phase_end ? state :
              state == FMAP1 ? FMAP2 :
              state == FMAP2 ? (kwords != '0 ? KERN : DONE) : DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            src1 <= '0;
            src2 <= '0;
            ksrc <= '0;
            dst2 <= '0;
            kdst <= '0;
            fwords <= '0;
            kwords <= '0;
            issued <= '0;
            written <= '0;
            outstd <= '0;
            dma_wen <= 1'b0;
            dma_wa <= '0;
            dma_wd <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            fmap_done <= 1'b0;
            kernel_done <= 1'b0;
        end else begin
            state <= nxt;
            outstd <= outstd + 3'(req_hs) - 3'(rsp_ok);
            issued <= nxt != state ? '0 : req_hs ? issued + CNT_WIDTH'(1) : issued;
            written <= nxt != state ? '0 : rsp_ok ? written + CNT_WIDTH'(1) : written;
            dma_wen <= rsp_ok;
            if (rsp_ok) begin
                dma_wa <= dst_base + (HWPE_ADDR_WIDTH'(written) << 3);
                dma_wd <= src_rsp_data;
            end
            busy <= nxt == FMAP1 || nxt == FMAP2 || nxt == KERN;
            done <= nxt == DONE;
            if (state == IDLE && start) begin
                src1 <= cfg_fmap_src1 & SRC_MASK;
                src2 <= cfg_fmap_src2 & SRC_MASK;
                ksrc <= cfg_kern_src & SRC_MASK;
                dst2 <= cfg_fmap_dst2 & DST_MASK;
                kdst <= cfg_kern_dst & DST_MASK;
                fwords <= cfg_fmap_words;
                kwords <= cfg_kern_words;
                fmap_done <= cfg_fmap_words == '0;
                kernel_done <= 1'b0;
            end
            if (state == FMAP2 && phase_end)
                fmap_done <= 1'b1;
            // every route into DONE has either written or skipped the kernel
            if (nxt == DONE)
                kernel_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hwpe_dma_loader.sv
// tb_hwpe_dma_loader: directed bench with an in-order source memory responder
// and a write-port monitor.
module tb_hwpe_dma_loader;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] cfg_fmap_src1, cfg_fmap_src2, cfg_kern_src;
    logic [15:0] cfg_fmap_dst2, cfg_kern_dst, cfg_fmap_words, cfg_kern_words;
    logic        src_req_valid;
    logic        src_req_ready = 1'b1;
    logic [31:0] src_req_addr;
    logic        src_rsp_valid = 1'b0;
    logic [63:0] src_rsp_data = '0;
    logic        dma_wen, busy, done, fmap_done, kernel_done;
    logic [15:0] dma_wa;
    logic [63:0] dma_wd;

    hwpe_dma_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_fmap_src1(cfg_fmap_src1), .cfg_fmap_src2(cfg_fmap_src2),
        .cfg_fmap_dst2(cfg_fmap_dst2), .cfg_fmap_words(cfg_fmap_words),
        .cfg_kern_src(cfg_kern_src), .cfg_kern_dst(cfg_kern_dst),
        .cfg_kern_words(cfg_kern_words),
        .src_req_valid(src_req_valid), .src_req_ready(src_req_ready),
        .src_req_addr(src_req_addr), .src_rsp_valid(src_rsp_valid),
        .src_rsp_data(src_rsp_data), .dma_wen(dma_wen), .dma_wa(dma_wa),
        .dma_wd(dma_wd), .busy(busy), .done(done), .fmap_done(fmap_done),
        .kernel_done(kernel_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, done_cnt = 0, done_cyc = 0, rsp_cyc = 0, wen_cyc = 0;
    int          hs_tot = 0, rsp_tot = 0, max_inflight = 0, stall_err = 0, lat = 1;
    bit          rand_mode = 1'b0, stall_pend = 1'b0;
    logic [31:0] stall_addr;
    logic [31:0] rq_addr[$];
    int          rq_due[$];
    logic [15:0] wa_q[$], exp_wa[$];
    logic [63:0] wd_q[$], exp_wd[$];
    logic        fd_q[$];

    function automatic logic [63:0] src_word(input logic [31:0] a);
        return {a ^ 32'h5A5AC3C3, ~a};
    endfunction

    // monitor first, then drive the responder for the coming posedge
    always @(negedge clk) begin
        cyc++;
        if (hs_tot - rsp_tot > max_inflight) max_inflight = hs_tot - rsp_tot;
        if (dma_wen === 1'b1) begin
            wa_q.push_back(dma_wa);
            wd_q.push_back(dma_wd);
            fd_q.push_back(fmap_done);
            wen_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_pend && (src_req_valid !== 1'b1 || src_req_addr !== stall_addr)) stall_err++;
        src_rsp_valid = 1'b0;
        if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            src_rsp_data = src_word(rq_addr.pop_front());
            void'(rq_due.pop_front());
            src_rsp_valid = 1'b1;
            rsp_tot++;
            rsp_cyc = cyc;
        end
        src_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        stall_pend = src_req_valid === 1'b1 && !src_req_ready;
        stall_addr = src_req_addr;
        if (src_req_valid === 1'b1 && src_req_ready) begin
            rq_addr.push_back(src_req_addr);
            rq_due.push_back(cyc + (rand_mode ? int'($urandom_range(1, 5)) : lat));
            hs_tot++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] s1, input logic [31:0] s2, input logic [15:0] d2,
                           input logic [15:0] fw, input logic [31:0] ks, input logic [15:0] kd,
                           input logic [15:0] kw);
        cfg_fmap_src1 = s1;
        cfg_fmap_src2 = s2;
        cfg_fmap_dst2 = d2;
        cfg_fmap_words = fw;
        cfg_kern_src = ks;
        cfg_kern_dst = kd;
        cfg_kern_words = kw;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_run();
        wa_q.delete();
        wd_q.delete();
        fd_q.delete();
        exp_wa.delete();
        exp_wd.delete();
    endtask

    task automatic exp_push(input logic [15:0] wa, input logic [31:0] sa);
        exp_wa.push_back(wa);
        exp_wd.push_back(src_word(sa));
    endtask

    task automatic exp_basic();
        exp_push(16'h0000, 32'h1000);
        exp_push(16'h0008, 32'h1008);
        exp_push(16'h0800, 32'h2000);
        exp_push(16'h0808, 32'h2008);
        exp_push(16'h4000, 32'h3000);
        exp_push(16'h4008, 32'h3008);
        exp_push(16'h4010, 32'h3010);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size(); i++) begin
            chk($sformatf("%s_wa%0d", tag, i), i < wa_q.size() ? 64'(wa_q[i]) : 64'bx, 64'(exp_wa[i]));
            chk($sformatf("%s_wd%0d", tag, i), i < wd_q.size() ? wd_q[i] : 64'bx, exp_wd[i]);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req_valid"}, 64'(src_req_valid), 64'd0);
        chk({tag, "_req_addr"}, 64'(src_req_addr), 64'd0);
        chk({tag, "_wen"}, 64'(dma_wen), 64'd0);
        chk({tag, "_wa"}, 64'(dma_wa), 64'd0);
        chk({tag, "_wd"}, dma_wd, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_fmap_done"}, 64'(fmap_done), 64'd0);
        chk({tag, "_kernel_done"}, 64'(kernel_done), 64'd0);
    endtask

    // waits for the next done pulse; optionally pokes start in the DONE cycle
    task automatic wait_done(input string tag, input bit poke);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        if (poke) pulse_start();
        repeat (3) step();
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, n, wr_at;
        rst_n = 1'b0;
        start = 1'b0;
        set_cfg('0, '0, '0, '0, '0, '0, '0);
        repeat (3) step();
        check_idle("rst");
        rst_n = 1'b1;
        step();
        check_idle("idle");

        // basic load, start poked in the DONE cycle
        set_cfg(32'h1000, 32'h2000, 16'h0800, 16'd2, 32'h3000, 16'h4000, 16'd3);
        clear_run();
        exp_basic();
        d0 = done_cnt;
        pulse_start();
        chk("basic_busy_start", 64'(busy), 64'd1);
        chk("basic_fd_cleared", 64'(fmap_done), 64'd0);
        wait_done("basic", 1'b1);
        cmp_writes("basic");
        chk("basic_fd_w4", fd_q.size() > 3 ? 64'(fd_q[3]) : 64'bx, 64'd0);
        chk("basic_fd_w5", fd_q.size() > 4 ? 64'(fd_q[4]) : 64'bx, 64'd1);
        chk("basic_one_done", 64'(done_cnt - d0), 64'd1);
        chk("basic_fmap_done", 64'(fmap_done), 64'd1);
        chk("basic_kernel_done", 64'(kernel_done), 64'd1);

        // backpressure, with start and cfg changes mid-run
        set_cfg(32'h1000, 32'h2000, 16'h0800, 16'd2, 32'h3000, 16'h4000, 16'd3);
        clear_run();
        exp_basic();
        stall_err = 0;
        max_inflight = 0;
        rand_mode = 1'b1;
        d0 = done_cnt;
        pulse_start();
        repeat (2) step();
        set_cfg(32'hAAA0, 32'hBBB0, 16'h1230, 16'd5, 32'hCCC0, 16'h2220, 16'd4);
        pulse_start();
        wait_done("bp", 1'b0);
        rand_mode = 1'b0;
        cmp_writes("bp");
        chk("bp_stall_stable", 64'(stall_err), 64'd0);
        chk("bp_max_outstd_le2", 64'(max_inflight <= 2), 64'd1);
        chk("bp_one_done", 64'(done_cnt - d0), 64'd1);

        // fmap phases skipped
        set_cfg('0, '0, 16'h0800, 16'd0, 32'h5000, 16'h6000, 16'd1);
        clear_run();
        exp_push(16'h6000, 32'h5000);
        pulse_start();
        chk("zero_fmap_done", 64'(fmap_done), 64'd1);
        chk("zero_kernel_done0", 64'(kernel_done), 64'd0);
        chk("zero_busy", 64'(busy), 64'd1);
        wait_done("zero", 1'b0);
        cmp_writes("zero");
        chk("zero_done_lat", 64'(done_cyc - rsp_cyc), 64'd2);
        chk("zero_wen_lat", 64'(wen_cyc - rsp_cyc), 64'd1);
        chk("zero_kernel_done", 64'(kernel_done), 64'd1);

        // all counts zero: straight to DONE
        set_cfg('0, '0, '0, 16'd0, '0, '0, 16'd0);
        pulse_start();
        chk("allz_done", 64'(done), 64'd1);
        chk("allz_busy", 64'(busy), 64'd0);
        chk("allz_flags", {62'd0, fmap_done, kernel_done}, 64'd3);
        step();
        chk("allz_done_pulse", 64'(done), 64'd0);

        // reset after the second kernel write with responses still pending
        set_cfg(32'h1000, 32'h2000, 16'h0800, 16'd2, 32'h3000, 16'h4000, 16'd3);
        clear_run();
        lat = 3;
        pulse_start();
        n = 0;
        while (wa_q.size() < 6 && n < 500) begin
            step();
            n++;
        end
        chk("rst_reach_w6", 64'(wa_q.size()), 64'd6);
        rst_n = 1'b0;
        wr_at = wa_q.size();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("rst_no_wen", 64'(wa_q.size()), 64'(wr_at));
        check_idle("mid_rst");
        lat = 1;
        clear_run();
        exp_basic();
        d0 = done_cnt;
        pulse_start();
        wait_done("fresh", 1'b0);
        cmp_writes("fresh");
        chk("fresh_one_done", 64'(done_cnt - d0), 64'd1);
        chk("fresh_kernel_done", 64'(kernel_done), 64'd1);

        // dst wrap-around and source low-bit masking
        set_cfg('0, '0, 16'h0800, 16'd0, 32'h7005, 16'hFFF8, 16'd2);
        clear_run();
        exp_push(16'hFFF8, 32'h7000);
        exp_push(16'h0000, 32'h7008);
        pulse_start();
        wait_done("wrap", 1'b0);
        cmp_writes("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
